// File: rtl/cpu_bus_mux_if.sv
// -----------------------------------------------------------------------------
// cpu_bus_mux_if
//
// Purpose:
//   Bundles the CPU-side and memory/peripheral-side signals of the 8-bit
//   soft-CPU bus so the address decoder can be connected through one port.
//
// Modports:
//   master : the decoder/multiplexer. It drives the read data, the CPU advance,
//            the strobes, the sticky error flag and the debug state.
//   slave  : the surrounding system (CPU core, RAM, ROM, peripherals).
//
// Signals:
//   cpu_next_addr[15:0]  address of the next access
//   cpu_next_rd          next access is a read
//   cpu_next_we          next access is a write
//   cpu_di[7:0]          read data to the CPU
//   cpu_enable           CPU advance (0 = stall, CPU holds cpu_next_*)
//   ram_we               RAM write strobe
//   ram_data[7:0]        RAM read data
//   rom_data[7:0]        ROM read data
//   slot_rd[NSLOTS-1:0]  per-slot read strobe
//   slot_wr[NSLOTS-1:0]  per-slot write strobe
//   slot_ack[NSLOTS-1:0] per-slot completion (ack-mode slots only)
//   slot_data            per-slot read data, slot i on [8i+7:8i]
//   bus_err              sticky bus-timeout flag
//   bus_err_clr          clears bus_err
//   dbg_state[1:0]       current decoder FSM state (0 IDLE, 1 WAIT, 2 ACKW, 3 TOUT)
// -----------------------------------------------------------------------------
interface cpu_bus_mux_if #(
    parameter int NSLOTS = 8
);
    logic [15:0]         cpu_next_addr;
    logic                cpu_next_rd;
    logic                cpu_next_we;
    logic [7:0]          cpu_di;
    logic                cpu_enable;
    logic                ram_we;
    logic [7:0]          ram_data;
    logic [7:0]          rom_data;
    logic [NSLOTS-1:0]   slot_rd;
    logic [NSLOTS-1:0]   slot_wr;
    logic [NSLOTS-1:0]   slot_ack;
    logic [NSLOTS*8-1:0] slot_data;
    logic                bus_err;
    logic                bus_err_clr;
    logic [1:0]          dbg_state;

    modport master (
        input  cpu_next_addr,
        input  cpu_next_rd,
        input  cpu_next_we,
        output cpu_di,
        output cpu_enable,
        output ram_we,
        input  ram_data,
        input  rom_data,
        output slot_rd,
        output slot_wr,
        input  slot_ack,
        input  slot_data,
        output bus_err,
        input  bus_err_clr,
        output dbg_state
    );

    modport slave (
        output cpu_next_addr,
        output cpu_next_rd,
        output cpu_next_we,
        input  cpu_di,
        input  cpu_enable,
        input  ram_we,
        output ram_data,
        output rom_data,
        input  slot_rd,
        input  slot_wr,
        output slot_ack,
        output slot_data,
        input  bus_err,
        output bus_err_clr,
        input  dbg_state
    );
endinterface

// File: rtl/cpu_bus_mux.sv
// -----------------------------------------------------------------------------
// cpu_bus_mux
//
// Purpose:
//   Address decoder and read-data multiplexer for the 8-bit soft-CPU bus.
//   Decodes RAM (0x0000-0x7FFF), ROM (0xE000-0xFFFF) and NSLOTS 256-byte
//   peripheral pages starting at page SLOT_BASE. Issues one-cycle read/write
//   strobes and stalls the CPU per slot, either for a fixed number of wait
//   states or until the slot acknowledges.
//
// Optional feature:
//   Define CPU_BUS_MUX_TIMEOUT_EN to bound the ack wait to TIMEOUT stall
//   cycles. On expiry the access is released with read data 8'hFF and the
//   sticky bus_err flag is set. Without the macro an ack-mode access waits
//   indefinitely and bus_err is constant 0.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    cpu_bus_mux_if.master (CPU, RAM, ROM and slot signals)
//
// Handshake:
//   The CPU presents cpu_next_* every cycle. A strobe is issued only from IDLE,
//   in the same cycle the access is presented. cpu_enable=0 means the CPU must
//   hold cpu_next_* unchanged; the cycle with cpu_enable=1 completes the access
//   and the read data appears on cpu_di in the following cycle.
// -----------------------------------------------------------------------------
module cpu_bus_mux #(
    parameter int                  NSLOTS    = 8,
    parameter logic [7:0]          SLOT_BASE = 8'hD0,
    parameter logic [NSLOTS*4-1:0] SLOT_WAIT = '0,
    parameter logic [NSLOTS-1:0]   SLOT_ACK  = '0,
    parameter int                  TIMEOUT   = 255
) (
    input  logic          clk,
    input  logic          reset,
    cpu_bus_mux_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACKW = 2'd2,
        S_TOUT = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_RAM  = 3'd1,
        SRC_ROM  = 3'd2,
        SRC_SLOT = 3'd3,
        SRC_ERR  = 3'd4
    } src_t;

    // FSM and datapath registers
    state_t            r_state;
    src_t              r_sel;
    logic [NSLOTS-1:0] r_sel_oh;    // slot whose data cpu_di shows when r_sel==SRC_SLOT
    logic [NSLOTS-1:0] r_slot_oh;   // slot of the access being stalled
    logic [3:0]        r_cnt;       // remaining wait states

    // Next-state / output signals
    state_t            w_state_next;
    src_t              w_sel_next;
    logic [3:0]        w_cnt_next;
    logic              w_cpu_enable;
    logic              w_ram_we;
    logic [NSLOTS-1:0] w_slot_rd;
    logic [NSLOTS-1:0] w_slot_wr;
    logic [7:0]        w_cpu_di;
    logic [7:0]        w_slot_rdata;

    // Decode signals
    logic [7:0]        w_page;
    logic              w_hit_ram;
    logic              w_hit_rom;
    logic              w_hit_slot;
    logic              w_access;
    logic [NSLOTS-1:0] w_slot_oh;
    logic [3:0]        w_slot_wait;
    logic              w_slot_is_ack;
    logic              w_slot_ack_now;
    logic              w_ack_latched;

`ifdef CPU_BUS_MUX_TIMEOUT_EN
    logic [9:0]        r_tcnt;      // stall cycles already spent on this ack access
    logic [9:0]        w_tcnt_next;
    logic              r_bus_err;
`endif

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    assign w_page    = bus.cpu_next_addr[15:8];
    assign w_hit_ram = ~bus.cpu_next_addr[15];
    assign w_hit_rom = (bus.cpu_next_addr[15:13] == 3'b111);
    assign w_access  = bus.cpu_next_rd | bus.cpu_next_we;

    // RAM and ROM take priority, so a slot page can never shadow them.
    always_comb begin
        w_slot_oh   = '0;
        w_slot_wait = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            if (!w_hit_ram && !w_hit_rom && (w_page == SLOT_BASE + 8'(i))) begin
                w_slot_oh[i] = 1'b1;
                w_slot_wait  = SLOT_WAIT[4*i +: 4];
            end
        end
    end

    assign w_hit_slot     = |w_slot_oh;
    assign w_slot_is_ack  = |(w_slot_oh & SLOT_ACK);
    assign w_slot_ack_now = |(w_slot_oh & bus.slot_ack);
    // Only the latched slot can complete a stalled access.
    assign w_ack_latched  = |(r_slot_oh & bus.slot_ack);

    // -------------------------------------------------------------------------
    // FSM: next state, strobes, stall
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_cpu_enable = 1'b1;
        w_ram_we     = 1'b0;
        w_slot_rd    = '0;
        w_slot_wr    = '0;
`ifdef CPU_BUS_MUX_TIMEOUT_EN
        w_tcnt_next  = r_tcnt;
`endif

        case (r_state)
            S_IDLE: begin
                w_ram_we  = w_hit_ram & bus.cpu_next_we;
                w_slot_rd = w_slot_oh & {NSLOTS{bus.cpu_next_rd}};
                w_slot_wr = w_slot_oh & {NSLOTS{bus.cpu_next_we}};
                if (w_hit_slot && w_access) begin
                    if (w_slot_is_ack) begin
                        if (!w_slot_ack_now) begin
                            w_cpu_enable = 1'b0;
`ifdef CPU_BUS_MUX_TIMEOUT_EN
                            // The issue cycle already counts as one stall cycle.
                            w_tcnt_next  = 10'd1;
                            w_state_next = (TIMEOUT == 1) ? S_TOUT : S_ACKW;
`else
                            w_state_next = S_ACKW;
`endif
                        end
                    end else if (w_slot_wait != 4'd0) begin
                        w_cpu_enable = 1'b0;
                        w_cnt_next   = w_slot_wait - 4'd1;
                        w_state_next = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (r_cnt != 4'd0) begin
                    w_cpu_enable = 1'b0;
                    w_cnt_next   = r_cnt - 4'd1;
                end else begin
                    w_state_next = S_IDLE;
                end
            end

            S_ACKW: begin
                w_cpu_enable = w_ack_latched;
                if (w_ack_latched) begin
                    w_state_next = S_IDLE;
                end
`ifdef CPU_BUS_MUX_TIMEOUT_EN
                else if (r_tcnt == 10'(TIMEOUT - 1)) begin
                    w_state_next = S_TOUT;
                end else begin
                    w_tcnt_next = r_tcnt + 10'd1;
                end
`endif
            end

            S_TOUT: begin
                // Release cycle of a timed-out access; a late ack is ignored.
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Reset suppresses every strobe and never stalls the CPU.
        if (reset) begin
            w_cpu_enable = 1'b1;
            w_ram_we     = 1'b0;
            w_slot_rd    = '0;
            w_slot_wr    = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Read-data source for the access completing in this cycle
    // -------------------------------------------------------------------------
    always_comb begin
        w_sel_next = SRC_NONE;
        if (r_state == S_TOUT) begin
            w_sel_next = SRC_ERR;
        end else if (bus.cpu_next_rd && !bus.cpu_next_we) begin
            if (w_hit_ram) begin
                w_sel_next = SRC_RAM;
            end else if (w_hit_rom) begin
                w_sel_next = SRC_ROM;
            end else if (w_hit_slot) begin
                w_sel_next = SRC_SLOT;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_sel     <= SRC_NONE;
            r_sel_oh  <= '0;
            r_slot_oh <= '0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            // The slot index is captured at issue and held through the stall.
            if (r_state == S_IDLE) begin
                r_slot_oh <= w_slot_oh;
            end
            if (w_cpu_enable) begin
                r_sel    <= w_sel_next;
                r_sel_oh <= w_slot_oh;
            end
        end
    end

`ifdef CPU_BUS_MUX_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tcnt    <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_tcnt <= w_tcnt_next;
            // A timeout wins over a simultaneous clear.
            if (r_state == S_TOUT) begin
                r_bus_err <= 1'b1;
            end else if (bus.bus_err_clr) begin
                r_bus_err <= 1'b0;
            end
        end
    end

    assign bus.bus_err = r_bus_err;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = bus.bus_err_clr;
    assign bus.bus_err      = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Read-data multiplexer
    // -------------------------------------------------------------------------
    always_comb begin
        w_slot_rdata = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            if (r_sel_oh[i]) begin
                w_slot_rdata = bus.slot_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        case (r_sel)
            SRC_RAM:  w_cpu_di = bus.ram_data;
            SRC_ROM:  w_cpu_di = bus.rom_data;
            SRC_SLOT: w_cpu_di = w_slot_rdata;
            SRC_ERR:  w_cpu_di = 8'hFF;
            default:  w_cpu_di = 8'h00;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.cpu_di     = w_cpu_di;
    assign bus.cpu_enable = w_cpu_enable;
    assign bus.ram_we     = w_ram_we;
    assign bus.slot_rd    = w_slot_rd;
    assign bus.slot_wr    = w_slot_wr;
    assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_cpu_bus_mux.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_cpu_bus_mux
//
// Bench for cpu_bus_mux with 4 slots at pages 0xD0..0xD3:
//   slot 0: 3 wait states, slot 1: zero wait, slot 2: ack mode, slot 3: 5 waits.
// The bench behaves as the CPU: it presents an access, holds it while
// cpu_enable is low, and predicts strobes, stall length, read data and bus_err
// from the address map and slot table.
// -----------------------------------------------------------------------------
module tb_cpu_bus_mux;

    localparam int NS        = 4;
    localparam int TIMEOUT_C = 4;
    localparam int RG_NONE   = 0;
    localparam int RG_RAM    = 1;
    localparam int RG_ROM    = 2;
    localparam int RG_SLOT   = 3;
`ifdef CPU_BUS_MUX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // ------------------------------------------------------------ clock/reset
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cpu_bus_mux_if #(.NSLOTS(NS)) bus ();

    cpu_bus_mux #(
        .NSLOTS    (NS),
        .SLOT_BASE (8'hD0),
        .SLOT_WAIT (16'h5003),
        .SLOT_ACK  (4'b0100),
        .TIMEOUT   (TIMEOUT_C)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ------------------------------------------------------------ reference
    int   wait_tab [NS] = '{3, 0, 0, 5};
    bit   ack_tab  [NS] = '{1'b0, 1'b0, 1'b1, 1'b0};

    logic [7:0] exp_q[$];
    logic       exp_err;
    logic       cur_clr;
    int         clr_mode;   // 0 random, 1 force 1, 2 force 0
    int         n_cmp;
    int         n_err;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void decode(input logic [15:0] a, output int rg, output int idx);
        int page;
        page = int'(a) / 256;
        idx  = 0;
        if (a < 16'h8000)                             rg = RG_RAM;
        else if (a >= 16'hE000)                       rg = RG_ROM;
        else if (page >= 'hD0 && page < 'hD0 + NS) begin
            rg  = RG_SLOT;
            idx = page - 'hD0;
        end else                                      rg = RG_NONE;
    endfunction

    function automatic logic [15:0] rand_addr();
        logic [15:0] a;
        case ($urandom_range(0, 4))
            0:       a = 16'($urandom_range(0, 16'h7FFF));
            1:       a = 16'($urandom_range(16'hE000, 16'hFFFF));
            2, 3:    a = {8'hD0 + 8'($urandom_range(0, NS - 1)), 8'($urandom)};
            default: a = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(16'h8000, 16'hCFFF))
                                                     : 16'($urandom_range(16'hD400, 16'hDFFF));
        endcase
        return a;
    endfunction

    // ------------------------------------------------------------ drivers
    task automatic drive_clr();
        case (clr_mode)
            1:       cur_clr = 1'b1;
            2:       cur_clr = 1'b0;
            default: cur_clr = ($urandom_range(0, 3) == 0);
        endcase
        bus.bus_err_clr = cur_clr;
    endtask

    // Random acks on every slot; the ack-mode target acks exactly at cycle dly.
    task automatic drive_ack(input bit tgt_ack, input int k, input int dly);
        logic [NS-1:0] n;
        n = NS'($urandom_range(0, (1 << NS) - 1));
        if (tgt_ack) n[2] = (k == dly);
        bus.slot_ack = n;
    endtask

    task automatic check_err_and_update(input bit tout_now);
        check_eq("bus_err", bus.bus_err, exp_err);
        if (tout_now)     exp_err = 1'b1;
        else if (cur_clr) exp_err = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        bus.cpu_next_addr = rand_addr();
        bus.cpu_next_rd   = 1'b0;
        bus.cpu_next_we   = 1'b0;
        drive_ack(1'b0, 0, 0);
        drive_clr();
        @(negedge clk);
        if (exp_q.size() > 0) check_eq("cpu_di", bus.cpu_di, exp_q.pop_front());
        check_eq("idle_enable", bus.cpu_enable, 1'b1);
        check_eq("idle_strobes", {bus.ram_we, bus.slot_rd, bus.slot_wr}, '0);
        check_err_and_update(1'b0);
    endtask

    task automatic do_access(input logic [15:0] addr, input logic rd, input logic we,
                             input int dly, input logic [7:0] dat);
        int          rg, idx, stall;
        bit          tout, tgt_ack, push;
        logic [7:0]  exp_d;
        logic        exp_ramwe;
        logic [NS-1:0] exp_rd, exp_wr;

        decode(addr, rg, idx);
        stall   = 0;
        tout    = 1'b0;
        tgt_ack = (rg == RG_SLOT) && ack_tab[idx];
        if (rg == RG_SLOT && (rd || we)) begin
            if (tgt_ack) begin
                if (TO_EN && dly >= TIMEOUT_C) begin
                    stall = TIMEOUT_C;
                    tout  = 1'b1;
                end else begin
                    stall = dly;
                end
            end else begin
                stall = wait_tab[idx];
            end
        end
        exp_ramwe = (rg == RG_RAM) && we;
        exp_rd    = (rg == RG_SLOT && rd) ? NS'(1 << idx) : '0;
        exp_wr    = (rg == RG_SLOT && we) ? NS'(1 << idx) : '0;

        @(posedge clk); #1;
        bus.cpu_next_addr = addr;
        bus.cpu_next_rd   = rd;
        bus.cpu_next_we   = we;
        drive_ack(tgt_ack, 0, dly);
        drive_clr();

        for (int k = 0; k <= stall; k++) begin
            @(negedge clk);
            if (k == 0) begin
                if (exp_q.size() > 0) check_eq("cpu_di", bus.cpu_di, exp_q.pop_front());
                bus.ram_data  = 8'($urandom);
                bus.rom_data  = 8'($urandom);
                bus.slot_data = 32'($urandom);
                case (rg)
                    RG_RAM:  bus.ram_data = dat;
                    RG_ROM:  bus.rom_data = dat;
                    RG_SLOT: bus.slot_data[idx*8 +: 8] = dat;
                    default: ;
                endcase
                check_eq("ram_we", bus.ram_we, exp_ramwe);
                check_eq("slot_rd", bus.slot_rd, exp_rd);
                check_eq("slot_wr", bus.slot_wr, exp_wr);
            end else begin
                check_eq("stall_strobes", {bus.ram_we, bus.slot_rd, bus.slot_wr}, '0);
            end
            check_eq("cpu_enable", bus.cpu_enable, (k == stall));
            check_err_and_update(tout && (k == stall));
            if (bus.cpu_enable) break;
            if (k < stall) begin
                @(posedge clk); #1;
                drive_ack(tgt_ack, k + 1, dly);
                drive_clr();
            end
        end

        push = tout || rd || we;
        if (tout)                  exp_d = 8'hFF;
        else if (we)               exp_d = 8'h00;
        else if (rg == RG_NONE)    exp_d = 8'h00;
        else                       exp_d = dat;
        if (push) exp_q.push_back(exp_d);
    endtask

    // Reset lands in the 2nd cycle of a 5-wait access to slot 3.
    task automatic reset_mid_access();
        @(posedge clk); #1;
        bus.cpu_next_addr = 16'hD310;
        bus.cpu_next_rd   = 1'b1;
        bus.cpu_next_we   = 1'b0;
        bus.slot_ack      = '0;
        drive_clr();
        @(negedge clk);
        if (exp_q.size() > 0) check_eq("cpu_di", bus.cpu_di, exp_q.pop_front());
        check_eq("rst_issue_rd", bus.slot_rd, 4'b1000);
        check_eq("rst_issue_en", bus.cpu_enable, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_cyc_en", bus.cpu_enable, 1'b1);
        check_eq("rst_cyc_strobes", {bus.ram_we, bus.slot_rd, bus.slot_wr}, '0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.cpu_next_rd = 1'b0;
        bus.bus_err_clr = 1'b0;
        cur_clr = 1'b0;
        exp_err = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_eq("post_rst_en", bus.cpu_enable, 1'b1);
        check_eq("post_rst_di", bus.cpu_di, 8'h00);
        check_eq("post_rst_strobes", {bus.ram_we, bus.slot_rd, bus.slot_wr}, '0);
        check_eq("post_rst_err", bus.bus_err, 1'b0);
    endtask

    // ------------------------------------------------------------ watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ main
    initial begin
        n_cmp    = 0;
        n_err    = 0;
        exp_err  = 1'b0;
        cur_clr  = 1'b0;
        clr_mode = 0;
        reset    = 1'b1;
        bus.cpu_next_addr = 16'hD000;
        bus.cpu_next_rd   = 1'b1;
        bus.cpu_next_we   = 1'b1;
        bus.ram_data      = 8'h00;
        bus.rom_data      = 8'h00;
        bus.slot_data     = '0;
        bus.slot_ack      = '0;
        bus.bus_err_clr   = 1'b0;

        // Reset: strobes suppressed and no stall even with a slot access presented.
        repeat (3) begin
            @(negedge clk);
            check_eq("reset_enable", bus.cpu_enable, 1'b1);
            check_eq("reset_strobes", {bus.ram_we, bus.slot_rd, bus.slot_wr}, '0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        bus.cpu_next_rd = 1'b0;
        bus.cpu_next_we = 1'b0;
        exp_q.push_back(8'h00);
        idle_cycle();

        // Directed cases
        do_access(16'h1234, 1'b1, 1'b0, 0, 8'h5A);   // RAM read
        idle_cycle();
        do_access(16'hD012, 1'b0, 1'b1, 0, 8'h00);   // slot 0 write, 3 waits
        idle_cycle();
        do_access(16'hD2A0, 1'b1, 1'b0, 5, 8'hC3);   // ack slot read, ack after 5
        idle_cycle();
        do_access(16'hC000, 1'b1, 1'b0, 0, 8'h00);   // unmapped then ROM, back to back
        do_access(16'hF000, 1'b1, 1'b0, 0, 8'h77);
        idle_cycle();
        do_access(16'hD155, 1'b1, 1'b0, 0, 8'h3C);   // zero-wait slot
        do_access(16'hD220, 1'b1, 1'b0, 0, 8'h96);   // ack in the issue cycle
        do_access(16'h4000, 1'b0, 1'b1, 0, 8'h00);   // RAM write
        do_access(16'hD3FF, 1'b1, 1'b0, 0, 8'hE7);   // slot 3, 5 waits
        idle_cycle();
        reset_mid_access();

        // Timeout with a simultaneous clear, then clear behaviour.
        clr_mode = 1;
        do_access(16'hD200, 1'b1, 1'b0, 9, 8'h11);
        clr_mode = 2;
        idle_cycle();
        idle_cycle();
        clr_mode = 1;
        idle_cycle();
        clr_mode = 2;
        idle_cycle();
        clr_mode = 0;

        // Randomised traffic
        for (int t = 0; t < 300; t++) begin
            logic [15:0] a;
            logic        r, w;
            int          sel;
            a   = rand_addr();
            sel = $urandom_range(0, 9);
            r   = (sel < 6);
            w   = (sel >= 6 && sel < 9);
            do_access(a, r, w, $urandom_range(0, 6), 8'($urandom));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
